// File: rtl/reg_window_ctrl.sv
`timescale 1ns/1ps
// Register-window controller: tracks the current window and spills or fills caller windows to and from a memory stack.
// Latency: a call or ret that hits a resident window completes on the next edge; a spill or fill adds two memory handshakes.
// Backpressure: ready drops for the whole spill/fill; mem_req and its address/data are held until mem_ack.
module reg_window_ctrl #(
    parameter int SP_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            call_req,
    input  logic            ret_req,
    output logic            ready,
    output logic            err,
    output logic [1:0]      window,
    output logic [1:0]      rf_window,
    output logic [1:0]      rf_reg,
    output logic            rf_we,
    output logic [15:0]     rf_wdata,
    input  logic [15:0]     rf_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [SP_W:0]   mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPILL0 = 3'd1,
        SPILL1 = 3'd2,
        FILL0  = 3'd3,
        FILL1  = 3'd4
    } state_t;

    localparam logic [SP_W-1:0] SP_MAX = '1;
    localparam logic [SP_W-1:0] SP_ONE = {{(SP_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [1:0]      cwp;
    logic [1:0]      resident;   // saved caller windows still held in the register file
    logic [SP_W-1:0] sp;         // windows held in the memory stack
    logic [1:0]      xferWin;    // victim window (spill) or target window (fill)
    logic            wordIdx;    // which of the two words of a window is moving

    assign ready   = (state == IDLE);
    assign window  = cwp;
    assign wordIdx = (state == SPILL1) || (state == FILL1);

    // Window bookkeeping and spill/fill sequencing; err is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cwp      <= 2'd0;
            resident <= 2'd0;
            sp       <= '0;
            xferWin  <= 2'd0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (call_req && ret_req) begin
                        err <= 1'b1;
                    end else if (call_req) begin
                        if (resident != 2'd2) begin
                            cwp      <= cwp + 2'd1;
                            resident <= resident + 2'd1;
                        end else if (sp != SP_MAX) begin
                            // oldest resident caller window makes room for the new one
                            xferWin <= cwp - 2'd2;
                            state   <= SPILL0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (ret_req) begin
                        if (resident != 2'd0) begin
                            cwp      <= cwp - 2'd1;
                            resident <= resident - 2'd1;
                        end else if (sp != '0) begin
                            xferWin <= cwp - 2'd1;
                            state   <= FILL0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SPILL0: if (mem_ack) state <= SPILL1;
                SPILL1: begin
                    if (mem_ack) begin
                        state <= IDLE;
                        sp    <= sp + SP_ONE;
                        cwp   <= cwp + 2'd1;
                    end
                end
                FILL0: if (mem_ack) state <= FILL1;
                FILL1: begin
                    if (mem_ack) begin
                        state <= IDLE;
                        sp    <= sp - SP_ONE;
                        cwp   <= cwp - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register-file and memory port steering, decoded from the current state.
    always_comb begin
        rf_window = cwp;
        rf_reg    = 2'd0;
        rf_we     = 1'b0;
        rf_wdata  = mem_rdata;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = rf_rdata;
        case (state)
            SPILL0, SPILL1: begin
                rf_window = xferWin;
                rf_reg    = {1'b0, wordIdx};
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {sp, wordIdx};
            end
            FILL0, FILL1: begin
                rf_window = xferWin;
                rf_reg    = {1'b0, wordIdx};
                rf_we     = mem_ack;
                mem_req   = 1'b1;
                mem_addr  = {sp - SP_ONE, wordIdx};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_window_ctrl.sv
`timescale 1ns/1ps
// Bench for reg_window_ctrl: register-file and memory models around the DUT, directed sequences with hand-computed results.
// Inputs change at posedge+1; outputs are sampled at negedge+2, after the memory model has answered.
// The memory model acks after a programmable number of request cycles.
module tb_reg_window_ctrl;

    localparam int SP_W = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          call_req = 1'b0;
    logic          ret_req = 1'b0;
    logic          ready;
    logic          err;
    logic [1:0]    window;
    logic [1:0]    rf_window;
    logic [1:0]    rf_reg;
    logic          rf_we;
    logic [15:0]   rf_wdata;
    logic [15:0]   rf_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [SP_W:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = 16'h0;
    logic          mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int ackDelay = 0;
    int waitCnt = 0;
    int reqCycles = 0;

    logic [15:0] rf  [4][4];
    logic [15:0] mem [128];

    // one entry per acknowledged memory access
    logic        logWe[$];
    logic [6:0]  logAddr[$];
    logic [15:0] logDat[$];
    logic        logRfWe[$];
    logic [1:0]  logRfWin[$];
    logic [1:0]  logRfReg[$];

    reg_window_ctrl #(.SP_W(SP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .call_req  (call_req),
        .ret_req   (ret_req),
        .ready     (ready),
        .err       (err),
        .window    (window),
        .rf_window (rf_window),
        .rf_reg    (rf_reg),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_window][rf_reg];

    // Memory model: counts request cycles, acks after ackDelay waits, logs the access.
    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                reqCycles++;
                waitCnt++;
                if (waitCnt > ackDelay) begin
                    waitCnt = 0;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    mem_ack = 1'b1;
                    #1;
                    logWe.push_back(mem_we);
                    logAddr.push_back(mem_addr);
                    logDat.push_back(mem_we ? mem_wdata : mem_rdata);
                    logRfWe.push_back(rf_we);
                    logRfWin.push_back(rf_window);
                    logRfReg.push_back(rf_reg);
                    if (rf_we) rf[rf_window][rf_reg] = rf_wdata;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // present a request for exactly one rising edge, return at the sample point after it
    task automatic pulse(input logic c, input logic r);
        call_req = c;
        ret_req  = r;
        @(posedge clk);
        #1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        tick();
    endtask

    task automatic waitReady(input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkVal("ready_wait", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int n;
        int base;
        for (int w = 0; w < 4; w++)
            for (int r = 0; r < 4; r++)
                rf[w][r] = 16'hA000 + 16'(w * 16 + r);
        for (int a = 0; a < 128; a++) mem[a] = 16'h0;

        // reset state
        repeat (3) tick();
        checkVal("rst_ready",  {31'd0, ready},   32'd1);
        checkVal("rst_err",    {31'd0, err},     32'd0);
        checkVal("rst_window", {30'd0, window},  32'd0);
        checkVal("rst_memreq", {31'd0, mem_req}, 32'd0);
        checkVal("rst_rfwe",   {31'd0, rf_we},   32'd0);
        rst = 1'b1;

        // underflow straight after reset
        pulse(1'b0, 1'b1);
        checkVal("under_err", {31'd0, err},    32'd1);
        checkVal("under_win", {30'd0, window}, 32'd0);
        tick();
        checkVal("under_err_clr", {31'd0, err}, 32'd0);
        checkVal("under_nomem", reqCycles, 32'd0);

        // simultaneous call and ret
        pulse(1'b1, 1'b1);
        checkVal("both_err", {31'd0, err},    32'd1);
        checkVal("both_win", {30'd0, window}, 32'd0);
        tick();

        // three calls, the third spills window 0 to slot 0
        pulse(1'b1, 1'b0);
        checkVal("call1_win",   {30'd0, window}, 32'd1);
        checkVal("call1_ready", {31'd0, ready},  32'd1);
        pulse(1'b1, 1'b0);
        checkVal("call2_win",   {30'd0, window}, 32'd2);
        checkVal("call2_ready", {31'd0, ready},  32'd1);
        pulse(1'b1, 1'b0);
        checkVal("call3_busy", {31'd0, ready}, 32'd0);
        checkVal("call3_req",  {31'd0, mem_req}, 32'd1);
        waitReady(20);
        checkVal("call3_win",  {30'd0, window}, 32'd3);
        checkVal("spill_cnt",  logAddr.size(), 32'd2);
        checkVal("spill0_we",  {31'd0, logWe[0]},  32'd1);
        checkVal("spill0_adr", {25'd0, logAddr[0]}, 32'd0);
        checkVal("spill0_dat", {16'd0, logDat[0]},  32'h0000A000);
        checkVal("spill1_adr", {25'd0, logAddr[1]}, 32'd1);
        checkVal("spill1_dat", {16'd0, logDat[1]},  32'h0000A001);

        // window 0 is free now; wipe it so the fill must restore it
        rf[0][0] = 16'h0;
        rf[0][1] = 16'h0;

        // three rets, the third fills window 0 from slot 0
        pulse(1'b0, 1'b1);
        checkVal("ret1_win", {30'd0, window}, 32'd2);
        pulse(1'b0, 1'b1);
        checkVal("ret2_win", {30'd0, window}, 32'd1);
        checkVal("ret_nomem", logAddr.size(), 32'd2);
        pulse(1'b0, 1'b1);
        checkVal("ret3_busy", {31'd0, ready}, 32'd0);
        waitReady(20);
        checkVal("ret3_win",   {30'd0, window}, 32'd0);
        checkVal("fill_cnt",   logAddr.size(), 32'd4);
        checkVal("fill0_we",   {31'd0, logWe[2]},    32'd0);
        checkVal("fill0_adr",  {25'd0, logAddr[2]},  32'd0);
        checkVal("fill1_adr",  {25'd0, logAddr[3]},  32'd1);
        checkVal("fill0_rfwe", {31'd0, logRfWe[2]},  32'd1);
        checkVal("fill0_rfw",  {30'd0, logRfWin[2]}, 32'd0);
        checkVal("fill1_rfr",  {30'd0, logRfReg[3]}, 32'd1);
        checkVal("fill_r0",    {16'd0, rf[0][0]},    32'h0000A000);
        checkVal("fill_r1",    {16'd0, rf[0][1]},    32'h0000A001);
        pulse(1'b0, 1'b1);
        checkVal("sp0_err", {31'd0, err}, 32'd1);
        tick();

        // slow memory: SPILL0 held for 5 cycles, requests ignored meanwhile
        ackDelay = 5;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkVal("hold_req",  {31'd0, mem_req},   32'd1);
            checkVal("hold_adr",  {25'd0, mem_addr},  32'd0);
            checkVal("hold_dat",  {16'd0, mem_wdata}, 32'h0000A000);
            checkVal("hold_err",  {31'd0, err},       32'd0);
            call_req = 1'b1;
            ret_req  = (i == 2);
            tick();
        end
        call_req = 1'b0;
        ret_req  = 1'b0;
        ackDelay = 0;
        checkVal("hold_err_end", {31'd0, err}, 32'd0);
        waitReady(20);
        checkVal("hold_win", {30'd0, window}, 32'd3);
        checkVal("hold_err_idle", {31'd0, err}, 32'd0);

        // reset in the middle of SPILL1 (slot 1, second word at address 3)
        ackDelay = 2;
        pulse(1'b1, 1'b0);
        n = 0;
        while (!(mem_req === 1'b1 && mem_addr == 7'd3) && n < 20) begin
            tick();
            n++;
        end
        checkVal("s1_adr", {25'd0, mem_addr},  32'd3);
        checkVal("s1_dat", {16'd0, mem_wdata}, 32'h0000A011);
        rst = 1'b0;
        #1;
        checkVal("arst_ready",  {31'd0, ready},   32'd1);
        checkVal("arst_memreq", {31'd0, mem_req}, 32'd0);
        checkVal("arst_win",    {30'd0, window},  32'd0);
        checkVal("arst_rfwe",   {31'd0, rf_we},   32'd0);
        checkVal("arst_err",    {31'd0, err},     32'd0);
        tick();
        tick();
        rst = 1'b1;
        ackDelay = 0;
        base = reqCycles;
        pulse(1'b1, 1'b0);
        checkVal("post_win",   {30'd0, window}, 32'd1);
        checkVal("post_ready", {31'd0, ready},  32'd1);
        tick();
        checkVal("post_nomem", reqCycles - base, 32'd0);

        // fill the stack to its maximum and overflow it
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 65; i++) begin
            pulse(1'b1, 1'b0);
            waitReady(10);
        end
        checkVal("full_win", {30'd0, window}, 32'd1);
        checkVal("full_adr", {25'd0, logAddr[logAddr.size() - 1]}, 32'd125);
        base = reqCycles;
        pulse(1'b1, 1'b0);
        checkVal("over_err", {31'd0, err},     32'd1);
        checkVal("over_win", {30'd0, window},  32'd1);
        checkVal("over_req", {31'd0, mem_req}, 32'd0);
        pulse(1'b0, 1'b1);
        checkVal("over_ret_win", {30'd0, window}, 32'd0);
        checkVal("over_ret_err", {31'd0, err},    32'd0);
        checkVal("over_nomem", reqCycles - base, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
